vga_scan_controller: RTL and testbench
======================================

Name: vga_scan_controller

Overview:
- Sequences the 640x480@60 Hz raster for the oscilloscope display from the 25 MHz pixel clock.
- Owns the horizontal and vertical scan counters and drives the per-line vertical-advance strobe.
- Generates hsync, vsync, video_on and pixel coordinates.
- Runs a start/stop state machine and a per-frame buffer-swap handshake with the waveform acquisition side, so the displayed trace only changes during vertical blanking.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0 when asserted

Ports:
- clk_25MHz  input  1  pixel clock, single clock domain
- rst_n  input  1  asynchronous active-low reset
- run  input  1  level; 1 = scan frames, 0 = stop at the next frame boundary
- swap_ack  input  1  acquisition side has swapped its display buffer
- H_count_Value  output  16  horizontal counter, 0..H_TOTAL-1
- V_count_Value  output  16  vertical counter, 0..V_TOTAL-1
- enable_V_counter  output  1  one-clock strobe on the last clock of each line
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- video_on  output  1  1 inside the active area
- pixel_x  output  10  H_count_Value when video_on, else 0
- pixel_y  output  10  V_count_Value when video_on, else 0
- frame_start  output  1  one-clock pulse at h=0, v=0 of every scanned frame
- swap_req  output  1  request for a buffer swap
- swap_miss  output  1  one-clock pulse when a swap request expires unacknowledged
- busy  output  1  1 in the RUN and STOPPING states

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Reset (asynchronous, while rst_n = 0):
  - state = IDLE; both counters = 0.
  - enable_V_counter, video_on, frame_start, swap_req, swap_miss, busy = 0.
  - pixel_x, pixel_y = 0.
  - hsync and vsync are deasserted (1 when SYNC_ACTIVE_LOW).
  - Reset mid-frame aborts the frame immediately; a pending swap_req is dropped with no swap_miss.
- States:
  - IDLE: counters held at 0, all outputs in reset values. Goes to RUN on the first clock where run = 1. The first RUN clock has h=0, v=0, and frame_start = 1 on that clock.
  - RUN: normal scanning. If run = 0 at any clock, go to STOPPING.
  - STOPPING: keep scanning. At the last clock of the frame (h=H_TOTAL-1, v=V_TOTAL-1):
    - if run = 1, return to RUN and keep scanning;
    - if run = 0, go to IDLE.
    - If run returns to 1 before the frame ends, go straight back to RUN.
  - Stopping is never mid-frame.
- Counters, updated on each clock in RUN or STOPPING:
  - h increments and wraps H_TOTAL-1 -> 0.
  - enable_V_counter = 1 combinationally while h = H_TOTAL-1.
  - v increments on that clock and wraps V_TOTAL-1 -> 0.
  - Comparisons use the full 16-bit values.
- Outputs are registered and aligned with the counter values of the same clock (zero latency relative to H_count_Value/V_count_Value):
  - hsync asserted for H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC (656..751).
  - vsync asserted for 490 <= v < 492.
  - video_on = (h < H_ACTIVE) && (v < V_ACTIVE).
  - frame_start = 1 when h=0, v=0 and state is not IDLE.
- Swap handshake:
  - swap_req rises on the first blanking clock of the frame (h=0, v=V_ACTIVE) while not IDLE.
  - swap_req stays high until swap_ack = 1 is sampled; it is low on the following clock.
  - If swap_ack is sampled on the same clock swap_req rises, swap_req is high for exactly that one clock.
  - Deadline: if swap_req is still high at h=H_TOTAL-1, v=V_TOTAL-1, then on the next clock swap_req = 0 and swap_miss pulses for one clock.
  - swap_ack while swap_req = 0 is ignored.
  - At most one request per frame.
  - If the block enters IDLE while swap_req is still high, the frame-end deadline applies first, so the request still ends with swap_miss.

Test Plan:
- Reset, run=1 for 2 frames -> frame_start every 420000 clocks; hsync low for 96 clocks starting at h=656; vsync low on lines 490-491; video_on high for 640x480=307200 clocks per frame.
- Line wrap -> enable_V_counter high only at h=799; v goes 479->480 and 524->0 on that clock; h wraps 799->0.
- swap_ack held 5 clocks after swap_req rises at h=0, v=480 -> swap_req high for exactly 6 clocks; no swap_miss.
- swap_ack never asserted -> swap_req high from (0,480) through (799,524); swap_miss pulses on the next clock, at (0,0) of the next frame.
- run dropped at v=100 -> scanning continues to (799,524), then IDLE with busy=0 and counters 0. A second run: deassert at v=100, reassert at v=300 -> no stop, scanning uninterrupted.
- rst_n asserted low at h=400, v=250 with swap_req idle, and again during swap_req high -> outputs at reset values immediately; no swap_miss; rst_n release with run=1 -> frame_start on the first clock.

Source files
------------

// File: rtl/vga_scan_controller.sv
// ---------------------------------------------------------------------------
// vga_scan_controller
//
// Raster sequencer for the oscilloscope display (640x480@60 Hz at 25 MHz by
// default). Owns the horizontal/vertical scan counters, generates sync,
// blanking and pixel coordinates, runs a start/stop state machine that only
// ever stops on a frame boundary, and handles a once-per-frame buffer-swap
// handshake with the acquisition side so the trace changes only in blanking.
//
// Ports:
//   clk_25MHz        in   pixel clock (single clock domain)
//   rst_n            in   asynchronous active-low reset
//   run              in   level: 1 = scan frames, 0 = stop at next frame end
//   swap_ack         in   acquisition side has swapped its display buffer
//   H_count_Value    out  horizontal counter, 0..H_TOTAL-1
//   V_count_Value    out  vertical counter, 0..V_TOTAL-1
//   enable_V_counter out  high on the last clock of each scanned line
//   hsync / vsync    out  sync pulses (polarity set by SYNC_ACTIVE_LOW)
//   video_on         out  inside the active area
//   pixel_x/pixel_y  out  counter values while video_on, else 0
//   frame_start      out  pulse at h=0, v=0 of every scanned frame
//   swap_req         out  buffer-swap request, raised at the first blank line
//   swap_miss        out  pulse when a request expires unacknowledged
//   busy             out  high while scanning (RUN or STOPPING)
// ---------------------------------------------------------------------------
module vga_scan_controller #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned H_FRONT         = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BACK          = 48,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_FRONT         = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BACK          = 33,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk_25MHz,
  input  logic        rst_n,
  input  logic        run,
  input  logic        swap_ack,
  output logic [15:0] H_count_Value,
  output logic [15:0] V_count_Value,
  output logic        enable_V_counter,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start,
  output logic        swap_req,
  output logic        swap_miss,
  output logic        busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FRONT);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FRONT);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FRONT + V_SYNC);

  // Sync pin level while the pulse is not asserted.
  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStopping
  } state_e;

  state_e      r_state;
  state_e      w_state_next;

  logic [15:0] r_h;
  logic [15:0] r_v;
  logic [15:0] w_h_next;
  logic [15:0] w_v_next;

  logic        r_hsync;
  logic        r_vsync;
  logic        r_video_on;
  logic [9:0]  r_pixel_x;
  logic [9:0]  r_pixel_y;
  logic        r_frame_start;
  logic        r_swap_req;
  logic        r_swap_miss;
  logic        r_busy;

  logic        w_scanning;
  logic        w_line_end;
  logic        w_frame_end;
  logic        w_scan_next;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_video_next;
  logic        w_frame_start_next;
  logic        w_req_rise;
  logic        w_swap_req_next;
  logic        w_swap_miss_next;

  assign w_scanning  = (r_state != StIdle);
  assign w_line_end  = w_scanning && (r_h == H_LAST);
  assign w_frame_end = w_line_end && (r_v == V_LAST);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic. STOPPING keeps scanning; it only falls back to
  // IDLE on the last clock of a frame, so a stop is never mid-frame.
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (run) w_state_next = StRun;
      end
      StRun: begin
        if (!run) w_state_next = StStopping;
      end
      StStopping: begin
        if (run) begin
          w_state_next = StRun;
        end else if (w_frame_end) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------
  // Scan counters next value. In IDLE they hold at 0, so the first RUN
  // clock after leaving IDLE sits at h=0, v=0.
  // ---------------------------------------------------------------------
  always_comb begin
    w_h_next = r_h;
    w_v_next = r_v;
    if (w_scanning) begin
      if (w_line_end) begin
        w_h_next = '0;
        w_v_next = (r_v == V_LAST) ? '0 : r_v + 16'd1;
      end else begin
        w_h_next = r_h + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM/output logic. Registered outputs are decoded from the *next*
  // counter values so that, once registered, they line up with
  // H_count_Value/V_count_Value on the same clock.
  // ---------------------------------------------------------------------
  always_comb begin
    w_scan_next        = (w_state_next != StIdle);
    w_hs_act           = w_scan_next && (w_h_next >= HS_START) && (w_h_next < HS_END);
    w_vs_act           = w_scan_next && (w_v_next >= VS_START) && (w_v_next < VS_END);
    w_video_next       = w_scan_next && (w_h_next < H_ACT) && (w_v_next < V_ACT);
    w_frame_start_next = w_scan_next && (w_h_next == '0) && (w_v_next == '0);
    w_req_rise         = w_scan_next && (w_h_next == '0) && (w_v_next == V_ACT);

    // Swap handshake. An ack sampled on the deadline clock still counts as
    // a successful swap; otherwise the frame end expires the request. This
    // also covers entering IDLE, which only happens on that same clock.
    w_swap_req_next  = r_swap_req;
    w_swap_miss_next = 1'b0;
    if (r_swap_req) begin
      if (swap_ack) begin
        w_swap_req_next = 1'b0;
      end else if (w_frame_end) begin
        w_swap_req_next  = 1'b0;
        w_swap_miss_next = 1'b1;
      end
    end else if (w_req_rise) begin
      w_swap_req_next = 1'b1;
    end
  end

  // Line-advance strobe is combinational from the registered h counter.
  assign enable_V_counter = w_line_end;

  // ---------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_h           <= '0;
      r_v           <= '0;
      r_hsync       <= SYNC_IDLE;
      r_vsync       <= SYNC_IDLE;
      r_video_on    <= 1'b0;
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_frame_start <= 1'b0;
      r_swap_req    <= 1'b0;
      r_swap_miss   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_h           <= w_h_next;
      r_v           <= w_v_next;
      r_hsync       <= w_hs_act ^ SYNC_IDLE;
      r_vsync       <= w_vs_act ^ SYNC_IDLE;
      r_video_on    <= w_video_next;
      r_pixel_x     <= w_video_next ? w_h_next[9:0] : 10'd0;
      r_pixel_y     <= w_video_next ? w_v_next[9:0] : 10'd0;
      r_frame_start <= w_frame_start_next;
      r_swap_req    <= w_swap_req_next;
      r_swap_miss   <= w_swap_miss_next;
      r_busy        <= w_scan_next;
    end
  end

  assign H_count_Value = r_h;
  assign V_count_Value = r_v;
  assign hsync         = r_hsync;
  assign vsync         = r_vsync;
  assign video_on      = r_video_on;
  assign pixel_x       = r_pixel_x;
  assign pixel_y       = r_pixel_y;
  assign frame_start   = r_frame_start;
  assign swap_req      = r_swap_req;
  assign swap_miss     = r_swap_miss;
  assign busy          = r_busy;

endmodule

// File: tb/tb_vga_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_controller
//
// Directed bench. u_dut uses a shrunken raster (25 x 19 clocks/lines) so
// whole frames, stops, swap handshakes and resets fit in a short run;
// u_big uses the default 640x480 timing and is checked along its first line.
// ---------------------------------------------------------------------------
module tb_vga_scan_controller;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;  // 25
  localparam int VT = VA + VF + VS + VB;  // 19
  localparam int FT = HT * VT;            // 475

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, run, swap_ack, run_big;

  logic [15:0] s_h, s_v, b_h, b_v;
  logic        s_env, s_hsync, s_vsync, s_video, s_fs, s_req, s_miss, s_busy;
  logic        b_env, b_hsync, b_vsync, b_video, b_fs, b_req, b_miss, b_busy;
  logic [9:0]  s_px, s_py, b_px, b_py;

  vga_scan_controller #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk_25MHz(clk), .rst_n(rst_n), .run(run), .swap_ack(swap_ack),
    .H_count_Value(s_h), .V_count_Value(s_v), .enable_V_counter(s_env),
    .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video),
    .pixel_x(s_px), .pixel_y(s_py), .frame_start(s_fs),
    .swap_req(s_req), .swap_miss(s_miss), .busy(s_busy)
  );

  vga_scan_controller u_big (
    .clk_25MHz(clk), .rst_n(rst_n), .run(run_big), .swap_ack(1'b0),
    .H_count_Value(b_h), .V_count_Value(b_v), .enable_V_counter(b_env),
    .hsync(b_hsync), .vsync(b_vsync), .video_on(b_video),
    .pixel_x(b_px), .pixel_y(b_py), .frame_start(b_fs),
    .swap_req(b_req), .swap_miss(b_miss), .busy(b_busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int sh = 0, sv = 0, bpos = 0;
  int c_vid, c_hs, c_vs, c_req, c_fs, c_env;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clocks; sample point is 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Move the small raster to (th, tv) using the bench's own position count.
  task automatic goto_s(input int th, input int tv);
    int n;
    n = ((tv * HT + th) - (sv * HT + sh) + FT) % FT;
    step(n);
    sh = th;
    sv = tv;
    chk("s_h_pos", 32'(s_h), th);
    chk("s_v_pos", 32'(s_v), tv);
  endtask

  task automatic goto_b(input int tpos);
    step(tpos - bpos);
    bpos = tpos;
    chk("b_h_pos", 32'(b_h), tpos % 800);
    chk("b_v_pos", 32'(b_v), tpos / 800);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; swap_ack = 1'b0; run_big = 1'b0;
    step(3);

    // Reset values
    chk("rst_h", 32'(s_h), 0);        chk("rst_v", 32'(s_v), 0);
    chk("rst_hsync", 32'(s_hsync), 1); chk("rst_vsync", 32'(s_vsync), 1);
    chk("rst_video", 32'(s_video), 0); chk("rst_busy", 32'(s_busy), 0);
    chk("rst_fs", 32'(s_fs), 0);       chk("rst_req", 32'(s_req), 0);
    chk("rst_miss", 32'(s_miss), 0);   chk("rst_env", 32'(s_env), 0);
    chk("rst_px", 32'(s_px), 0);       chk("rst_py", 32'(s_py), 0);
    chk("rst_b_hsync", 32'(b_hsync), 1);

    // IDLE holds with run low
    rst_n = 1'b1;
    step(2);
    chk("idle_busy", 32'(s_busy), 0); chk("idle_h", 32'(s_h), 0);
    chk("idle_video", 32'(s_video), 0);

    // Start: first RUN clock is (0,0) with frame_start
    run = 1'b1;
    step(1); sh = 0; sv = 0;
    chk("start_fs", 32'(s_fs), 1);   chk("start_busy", 32'(s_busy), 1);
    chk("start_video", 32'(s_video), 1);
    chk("start_h", 32'(s_h), 0);     chk("start_v", 32'(s_v), 0);
    chk("big_still_idle", 32'(b_busy), 0);

    goto_s(1, 0);  chk("fs_one_clock", 32'(s_fs), 0);
    goto_s(15, 0); chk("video_last_px", 32'(s_video), 1); chk("px_15", 32'(s_px), 15);
    goto_s(16, 0); chk("video_h_blank", 32'(s_video), 0); chk("px_blank", 32'(s_px), 0);
    goto_s(17, 0); chk("hsync_before", 32'(s_hsync), 1);
    goto_s(18, 0); chk("hsync_first", 32'(s_hsync), 0);
    goto_s(21, 0); chk("hsync_last", 32'(s_hsync), 0);
    goto_s(22, 0); chk("hsync_after", 32'(s_hsync), 1);
    goto_s(23, 0); chk("env_early", 32'(s_env), 0);
    goto_s(24, 0); chk("env_line_end", 32'(s_env), 1);
    goto_s(0, 1);  chk("env_after_wrap", 32'(s_env), 0);
    goto_s(5, 11); chk("video_last_line", 32'(s_video), 1); chk("py_11", 32'(s_py), 11);
    goto_s(24, 11); chk("req_before", 32'(s_req), 0);

    // Swap request rises at (0, VA); ack held 5 clocks later -> 6 clocks high
    goto_s(0, 12); chk("req_rise", 32'(s_req), 1); chk("video_v_blank", 32'(s_video), 0);
    chk("py_blank", 32'(s_py), 0);
    goto_s(5, 12); chk("req_held", 32'(s_req), 1);
    swap_ack = 1'b1;
    goto_s(6, 12); chk("req_acked", 32'(s_req), 0);
    goto_s(7, 12); chk("ack_ignored", 32'(s_req), 0);
    swap_ack = 1'b0;

    goto_s(24, 13); chk("vsync_before", 32'(s_vsync), 1);
    goto_s(0, 14);  chk("vsync_first", 32'(s_vsync), 0);
    goto_s(24, 15); chk("vsync_last", 32'(s_vsync), 0);
    goto_s(0, 16);  chk("vsync_after", 32'(s_vsync), 1);
    goto_s(24, 18); chk("env_frame_end", 32'(s_env), 1);
    goto_s(0, 0);   chk("fs_frame2", 32'(s_fs), 1); chk("no_miss_acked", 32'(s_miss), 0);
    chk("req_low_frame2", 32'(s_req), 0);

    // Frame 2: whole-frame counts, no ack given
    c_vid = 0; c_hs = 0; c_vs = 0; c_req = 0; c_fs = 0; c_env = 0;
    for (int i = 0; i < FT; i++) begin
      if (s_video) c_vid++;
      if (!s_hsync) c_hs++;
      if (!s_vsync) c_vs++;
      if (s_req) c_req++;
      if (s_fs) c_fs++;
      if (s_env) c_env++;
      step(1);
    end
    chk("cnt_video", c_vid, HA * VA);
    chk("cnt_hsync", c_hs, HS * VT);
    chk("cnt_vsync", c_vs, VS * HT);
    chk("cnt_req", c_req, (VT - VA) * HT);
    chk("cnt_fs", c_fs, 1);
    chk("cnt_env", c_env, VT);

    // Frame 3 start: expired request
    chk("miss_pulse", 32'(s_miss), 1); chk("miss_req_low", 32'(s_req), 0);
    chk("fs_frame3", 32'(s_fs), 1);    chk("f3_h", 32'(s_h), 0);
    goto_s(1, 0); chk("miss_one_clock", 32'(s_miss), 0);

    // Stop requested mid-frame: finish the frame, then IDLE
    goto_s(0, 5); run = 1'b0;
    goto_s(1, 5);   chk("stopping_busy", 32'(s_busy), 1);
    goto_s(24, 18); chk("stopping_end_busy", 32'(s_busy), 1);
    chk("stopping_req", 32'(s_req), 1);
    step(1);
    chk("idle_h0", 32'(s_h), 0);        chk("idle_v0", 32'(s_v), 0);
    chk("idle_busy0", 32'(s_busy), 0);  chk("idle_fs0", 32'(s_fs), 0);
    chk("idle_miss", 32'(s_miss), 1);   chk("idle_req0", 32'(s_req), 0);
    chk("idle_video0", 32'(s_video), 0);
    step(1);
    chk("idle_miss_done", 32'(s_miss), 0); chk("idle_hold_h", 32'(s_h), 0);
    step(3);
    chk("idle_hold_busy", 32'(s_busy), 0); chk("idle_hold_h2", 32'(s_h), 0);

    // Restart; drop run at v=5, restore at v=9: no stop
    run = 1'b1;
    step(1); sh = 0; sv = 0;
    chk("restart_fs", 32'(s_fs), 1); chk("restart_busy", 32'(s_busy), 1);
    goto_s(0, 5); run = 1'b0;
    goto_s(0, 9); chk("blip_busy", 32'(s_busy), 1);
    run = 1'b1;
    goto_s(0, 0); chk("blip_fs", 32'(s_fs), 1); chk("blip_busy2", 32'(s_busy), 1);
    chk("blip_miss", 32'(s_miss), 1);
    goto_s(1, 0); chk("blip_scanning", 32'(s_busy), 1);

    // Async reset mid-frame, no request pending
    goto_s(10, 6); chk("pre_rst_video", 32'(s_video), 1); chk("pre_rst_req", 32'(s_req), 0);
    rst_n = 1'b0;
    #2;
    chk("arst_h", 32'(s_h), 0);       chk("arst_v", 32'(s_v), 0);
    chk("arst_video", 32'(s_video), 0); chk("arst_px", 32'(s_px), 0);
    chk("arst_busy", 32'(s_busy), 0); chk("arst_hsync", 32'(s_hsync), 1);
    step(2);
    chk("arst_miss", 32'(s_miss), 0);
    rst_n = 1'b1;
    step(1); sh = 0; sv = 0;
    chk("arst_rel_fs", 32'(s_fs), 1); chk("arst_rel_h", 32'(s_h), 0);
    chk("arst_rel_busy", 32'(s_busy), 1);

    // Async reset while swap_req is high: request dropped, no miss
    goto_s(3, 13); chk("pre_rst2_req", 32'(s_req), 1);
    rst_n = 1'b0;
    #2;
    chk("arst2_req", 32'(s_req), 0);   chk("arst2_miss", 32'(s_miss), 0);
    chk("arst2_vsync", 32'(s_vsync), 1); chk("arst2_h", 32'(s_h), 0);
    step(2);
    rst_n = 1'b1;
    step(1); sh = 0; sv = 0;
    chk("arst2_rel_fs", 32'(s_fs), 1); chk("arst2_rel_req", 32'(s_req), 0);
    chk("arst2_rel_miss", 32'(s_miss), 0);
    goto_s(1, 0); chk("arst2_no_miss", 32'(s_miss), 0);

    // Default 640x480 timing along the first line
    run_big = 1'b1;
    step(1); bpos = 0;
    chk("b_fs", 32'(b_fs), 1); chk("b_busy", 32'(b_busy), 1);
    chk("b_h0", 32'(b_h), 0);  chk("b_video0", 32'(b_video), 1);
    goto_b(639); chk("b_video639", 32'(b_video), 1); chk("b_px639", 32'(b_px), 639);
    chk("b_py0", 32'(b_py), 0);
    goto_b(640); chk("b_video640", 32'(b_video), 0); chk("b_px640", 32'(b_px), 0);
    goto_b(655); chk("b_hsync655", 32'(b_hsync), 1);
    goto_b(656); chk("b_hsync656", 32'(b_hsync), 0);
    goto_b(751); chk("b_hsync751", 32'(b_hsync), 0);
    goto_b(752); chk("b_hsync752", 32'(b_hsync), 1);
    goto_b(798); chk("b_env798", 32'(b_env), 0);
    goto_b(799); chk("b_env799", 32'(b_env), 1); chk("b_vsync", 32'(b_vsync), 1);
    goto_b(800); chk("b_env_wrap", 32'(b_env), 0); chk("b_fs_line1", 32'(b_fs), 0);
    chk("b_req", 32'(b_req), 0); chk("b_miss", 32'(b_miss), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
